pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 44 ++++
 rtl/sat_counter.sv | 34 +++
 rtl/pipe_stage_reg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, payload layouts and occupancy states for pipe_stage_reg.
// Build option PIPE_STAGE_REG_SKID_EN selects the two-entry skid variant.
package pipe_pkg;

    localparam int unsigned IDEX_CTRL_W  = 22;
    localparam int unsigned IDEX_DATA_W  = 175;
    localparam int unsigned EXMEM_CTRL_W = 12;
    localparam int unsigned EXMEM_DATA_W = 106;
    localparam int unsigned MEMWB_CTRL_W = 4;
    localparam int unsigned MEMWB_DATA_W = 69;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [4:0] alu_type;
        logic [2:0] imm_type;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic [1:0] csr_op;
    } ctrl_idex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } data_idex_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_BOTH  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached until cleared.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_REG_SKID_EN for a registered-ready two-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = IDEX_CTRL_W,
    parameter int unsigned DATA_W     = IDEX_DATA_W,
    parameter int unsigned CLEAR_DATA = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state_q;
    state_t            state_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_w;
    logic              accept;
    logic              drain;

    assign valid_w = (state_q != ST_EMPTY);
    assign accept  = in_valid && in_ready;
    assign drain   = valid_w && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic              rdy_q;
    logic              rdy_d;

    assign in_ready  = rdy_q;
    assign occupancy = {state_q == ST_BOTH, state_q == ST_MAIN};
`else
    assign in_ready  = !valid_w || out_ready;
    assign occupancy = {1'b0, valid_w};
`endif

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
`ifdef PIPE_STAGE_REG_SKID_EN
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        rdy_d       = rdy_q;
`endif
        if (flush) begin
            // Any same-cycle accept is dropped here on purpose.
            state_d = ST_EMPTY;
            ctrl_d  = '0;
            if (CLEAR_DATA != 0) begin
                data_d = '0;
            end
`ifdef PIPE_STAGE_REG_SKID_EN
            skid_ctrl_d = '0;
            if (CLEAR_DATA != 0) begin
                skid_data_d = '0;
            end
            rdy_d = 1'b1;
`endif
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_MAIN;
                        ctrl_d  = in_ctrl;
                        data_d  = in_data;
                    end
                end
                ST_MAIN: begin
                    if (accept && drain) begin
                        ctrl_d = in_ctrl;
                        data_d = in_data;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                        ctrl_d  = '0;
`ifdef PIPE_STAGE_REG_SKID_EN
                    end else if (accept) begin
                        state_d     = ST_BOTH;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        rdy_d       = 1'b0;
`endif
                    end
                end
`ifdef PIPE_STAGE_REG_SKID_EN
                ST_BOTH: begin
                    if (drain) begin
                        state_d     = ST_MAIN;
                        ctrl_d      = skid_ctrl_q;
                        data_d      = skid_data_q;
                        skid_ctrl_d = '0;
                        rdy_d       = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                    ctrl_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            rdy_q       <= 1'b1;
        end else begin
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            rdy_q       <= rdy_d;
        end
    end
`endif

    assign out_valid = valid_w;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clear(rst),
        .inc  (valid_w && !out_ready),
        .cnt  (stall_cnt)
    );

endmodule
